// File: rtl/datapath_pkg.sv
// Shared constants for the register-file datapath.
// ALU function codes, default widths and the register-address width helper.
package datapath_pkg;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_OR  = 2'b11;

  localparam int DEF_W    = 16;
  localparam int DEF_NREG = 4;

  function automatic int aw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/datapath_rf_alu.sv
// Shared ALU, evaluated one bit wider than the data path.
// The top bit of the wide result becomes the N flag (carry/borrow).
module datapath_rf_alu
  import datapath_pkg::*;
#(
  parameter int WA = DEF_W + 1
) (
  input  logic [1:0]    fn,
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  output logic [WA-2:0] y,
  output logic          n,
  output logic          z
);

  logic [WA-1:0] r;

  always_comb begin
    r = '0;
    unique case (fn)
      FN_ADD:  r = a + b;
      FN_SUB:  r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      default: r = '0;
    endcase
  end

  assign y = r[WA-2:0];
  assign n = r[WA-1];
  assign z = (r[WA-2:0] == '0);

endmodule

// File: rtl/datapath_rf.sv
// Register file plus shared ALU behind valid/ready command and result streams.
// Two stages: operand latch (S1), then execute/writeback into the result register.
module datapath_rf
  import datapath_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NREG = DEF_NREG,
  localparam int AW  = aw_of(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [1:0]    cmd_fn,
  input  logic          cmd_wen,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_sa,
  input  logic [AW-1:0] cmd_sb,
  input  logic [W-1:0]  cmd_imm,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_n,
  output logic          res_z
);

  logic [W-1:0]  rf [NREG];

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic          s1_ld;
  logic [1:0]    s1_fn;
  logic          s1_wen;
  logic [AW-1:0] s1_dst;

  logic          adv;
  logic          acc;
  logic [W-1:0]  alu_y;
  logic          alu_n;
  logic          alu_z;
  logic [W-1:0]  ex_data;
  logic          ex_n;
  logic          ex_z;
  logic          fwd_a;
  logic          fwd_b;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;

  assign adv       = s1_valid & (~res_valid | res_ready);
  assign cmd_ready = ~s1_valid | adv;
  assign acc       = cmd_valid & cmd_ready;

  datapath_rf_alu #(.WA(W + 1)) u_alu (
    .fn (s1_fn),
    .a  ({1'b0, s1_a}),
    .b  ({1'b0, s1_b}),
    .y  (alu_y),
    .n  (alu_n),
    .z  (alu_z)
  );

  // Loads carry their immediate in the A slot.
  assign ex_data = s1_ld ? s1_a : alu_y;
  assign ex_n    = s1_ld ? 1'b0 : alu_n;
  assign ex_z    = s1_ld ? (s1_a == '0) : alu_z;

  assign fwd_a = adv & s1_wen & (s1_dst == cmd_sa);
  assign fwd_b = adv & s1_wen & (s1_dst == cmd_sb);

  always_comb begin
    op_a = fwd_a ? ex_data : rf[cmd_sa];
    op_b = fwd_b ? ex_data : rf[cmd_sb];
    if (cmd_ld) begin
      op_a = cmd_imm;
      op_b = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (adv && s1_wen) begin
      rf[s1_dst] <= ex_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ld    <= 1'b0;
      s1_fn    <= FN_ADD;
      s1_wen   <= 1'b0;
      s1_dst   <= '0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_a     <= op_a;
      s1_b     <= op_b;
      s1_ld    <= cmd_ld;
      s1_fn    <= cmd_fn;
      s1_wen   <= cmd_wen;
      s1_dst   <= cmd_dst;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_n     <= 1'b0;
      res_z     <= 1'b0;
    end else if (adv) begin
      res_valid <= 1'b1;
      res_data  <= ex_data;
      res_n     <= ex_n;
      res_z     <= ex_z;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
